approx_err_monitor: RTL and testbench

Streaming error-measurement stage placed directly downstream of the approximate `max` partition circuits. Each cycle it may accept one pair (exact `po` word from the golden netlist, approximate `po` word from the BMF-approximated netlist, both driven by the same `pi` vector). It accumulates mismatch count, total Hamming distance, sum of absolute error and maximum absolute error over a fixed window. It then presents one report over a valid/ready handshake. The block is the on-chip counterpart of the error metrics used to rank candidate factorization degrees `k`.

---
 rtl/approx_mon_pkg.sv | 30 +++
 rtl/approx_sample_metric.sv | 32 +++
 rtl/approx_err_monitor.sv | 154 +++++++++++++++
 tb/tb_approx_err_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mon_pkg.sv
// rtl/approx_mon_pkg.sv - shared state encoding and width helpers for the approximate-error monitor
package approx_mon_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } mon_state_e;

  // Width of a per-sample popcount (0..w)
  function automatic int sample_hd_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Sample counter / mismatch count width (0..window)
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

  // Hamming-distance sum width (0..window*w)
  function automatic int hd_width(input int w, input int window);
    return $clog2(window * w + 1);
  endfunction

  // Absolute-error sum width (0..window*(2^w-1))
  function automatic int abs_width(input int w, input int window);
    return $clog2(window * ((1 << w) - 1) + 1);
  endfunction

endpackage

// File: rtl/approx_sample_metric.sv
// rtl/approx_sample_metric.sv - per-sample mismatch flag, Hamming distance and absolute difference
module approx_sample_metric
  import approx_mon_pkg::*;
#(
  parameter int  W   = 5,
  localparam int HDW = sample_hd_width(W)
) (
  input  logic [W-1:0]   exact,
  input  logic [W-1:0]   approx,
  output logic           mis,
  output logic [HDW-1:0] hd,
  output logic [W-1:0]   ad
);

  logic [W-1:0] diff_x;

  // Compare the two words: any differing bit, popcount of the difference, magnitude of the error
  always_comb begin
    diff_x = exact ^ approx;
    mis    = |diff_x;
    hd     = '0;
    for (int i = 0; i < W; i++) begin
      hd = hd + HDW'(diff_x[i]);
    end
    if (exact >= approx) begin
      ad = exact - approx;
    end else begin
      ad = approx - exact;
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - windowed error statistics between exact and approximate output words
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int  W      = 5,
  parameter int  WINDOW = 1024,
  localparam int CW     = cnt_width(WINDOW),
  localparam int HW     = hd_width(W, WINDOW),
  localparam int AW     = abs_width(W, WINDOW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  exact,
  input  logic [W-1:0]  approx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] err_cnt,
  output logic [HW-1:0] hd_sum,
  output logic [AW-1:0] abs_sum,
  output logic [W-1:0]  max_abs
);

  localparam int SHW = sample_hd_width(W);

  mon_state_e     state_q, state_d;
  logic [CW-1:0]  n_q, n_d;
  logic           s1_vld_q, s1_vld_d;
  logic           s1_mis_q, s1_mis_d;
  logic [SHW-1:0] s1_hd_q, s1_hd_d;
  logic [W-1:0]   s1_ad_q, s1_ad_d;
  logic [CW-1:0]  err_cnt_q, err_cnt_d;
  logic [HW-1:0]  hd_sum_q, hd_sum_d;
  logic [AW-1:0]  abs_sum_q, abs_sum_d;
  logic [W-1:0]   max_abs_q, max_abs_d;

  logic           met_mis;
  logic [SHW-1:0] met_hd;
  logic [W-1:0]   met_ad;
  logic           accept;
  logic           last_sample;
  logic           report_taken;

  approx_sample_metric #(
    .W (W)
  ) u_metric (
    .exact  (exact),
    .approx (approx),
    .mis    (met_mis),
    .hd     (met_hd),
    .ad     (met_ad)
  );

  // Handshake outputs come from the state register alone so no input reaches them combinationally
  always_comb begin
    in_ready     = (state_q == ST_ACCUM);
    out_valid    = (state_q == ST_REPORT);
    accept       = in_valid && in_ready;
    last_sample  = (n_q == CW'(WINDOW - 1));
    report_taken = out_valid && out_ready;
    err_cnt      = err_cnt_q;
    hd_sum       = hd_sum_q;
    abs_sum      = abs_sum_q;
    max_abs      = max_abs_q;
  end

  // Window sequencing: collect WINDOW samples, one drain cycle for the pipeline, then hold the report
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM:  if (accept && last_sample) state_d = ST_DRAIN;
        ST_DRAIN:  state_d = ST_REPORT;
        ST_REPORT: if (out_ready) state_d = ST_ACCUM;
        default:   state_d = ST_ACCUM;
      endcase
    end
  end

  // Metric stage, accumulators and sample counter; clr wipes everything including an in-flight sample
  always_comb begin
    n_d       = n_q;
    s1_vld_d  = accept;
    s1_mis_d  = s1_mis_q;
    s1_hd_d   = s1_hd_q;
    s1_ad_d   = s1_ad_q;
    err_cnt_d = err_cnt_q;
    hd_sum_d  = hd_sum_q;
    abs_sum_d = abs_sum_q;
    max_abs_d = max_abs_q;

    if (accept) begin
      s1_mis_d = met_mis;
      s1_hd_d  = met_hd;
      s1_ad_d  = met_ad;
      n_d      = last_sample ? '0 : n_q + CW'(1);
    end

    if (s1_vld_q) begin
      err_cnt_d = err_cnt_q + CW'(s1_mis_q);
      hd_sum_d  = hd_sum_q + HW'(s1_hd_q);
      abs_sum_d = abs_sum_q + AW'(s1_ad_q);
      if (s1_ad_q > max_abs_q) max_abs_d = s1_ad_q;
    end

    if (report_taken) begin
      err_cnt_d = '0;
      hd_sum_d  = '0;
      abs_sum_d = '0;
      max_abs_d = '0;
    end

    if (clr) begin
      n_d       = '0;
      s1_vld_d  = 1'b0;
      err_cnt_d = '0;
      hd_sum_d  = '0;
      abs_sum_d = '0;
      max_abs_d = '0;
    end
  end

  // State, pipeline and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      n_q       <= '0;
      s1_vld_q  <= 1'b0;
      s1_mis_q  <= 1'b0;
      s1_hd_q   <= '0;
      s1_ad_q   <= '0;
      err_cnt_q <= '0;
      hd_sum_q  <= '0;
      abs_sum_q <= '0;
      max_abs_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      s1_vld_q  <= s1_vld_d;
      s1_mis_q  <= s1_mis_d;
      s1_hd_q   <= s1_hd_d;
      s1_ad_q   <= s1_ad_d;
      err_cnt_q <= err_cnt_d;
      hd_sum_q  <= hd_sum_d;
      abs_sum_q <= abs_sum_d;
      max_abs_q <= max_abs_d;
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - self-checking bench for approx_err_monitor
module tb_approx_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vin[2];
  logic [4:0] ex[2];
  logic [4:0] ap[2];
  logic       ordy[2];
  logic       clr_s[2];

  logic       ir4, ov4, ir1, ov1;
  logic [2:0] err4;
  logic [4:0] hd4;
  logic [6:0] abs4;
  logic [4:0] max4;
  logic [0:0] err1;
  logic [2:0] hd1;
  logic [4:0] abs1;
  logic [4:0] max1;

  logic        o_ir[2];
  logic        o_ov[2];
  logic [31:0] o_err[2];
  logic [31:0] o_hd[2];
  logic [31:0] o_abs[2];
  logic [31:0] o_max[2];

  approx_err_monitor #(.W(5), .WINDOW(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s[0]),
    .in_valid  (vin[0]),
    .in_ready  (ir4),
    .exact     (ex[0]),
    .approx    (ap[0]),
    .out_valid (ov4),
    .out_ready (ordy[0]),
    .err_cnt   (err4),
    .hd_sum    (hd4),
    .abs_sum   (abs4),
    .max_abs   (max4)
  );

  approx_err_monitor #(.W(5), .WINDOW(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s[1]),
    .in_valid  (vin[1]),
    .in_ready  (ir1),
    .exact     (ex[1]),
    .approx    (ap[1]),
    .out_valid (ov1),
    .out_ready (ordy[1]),
    .err_cnt   (err1),
    .hd_sum    (hd1),
    .abs_sum   (abs1),
    .max_abs   (max1)
  );

  always_comb begin
    o_ir[0]  = ir4;
    o_ov[0]  = ov4;
    o_err[0] = 32'(err4);
    o_hd[0]  = 32'(hd4);
    o_abs[0] = 32'(abs4);
    o_max[0] = 32'(max4);
    o_ir[1]  = ir1;
    o_ov[1]  = ov1;
    o_err[1] = 32'(err1);
    o_hd[1]  = 32'(hd1);
    o_abs[1] = 32'(abs1);
    o_max[1] = 32'(max1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model: plain window sums, a report is due two cycles after the window's last accept
  int win[2] = '{4, 1};
  int cyc = 0;
  int t_done[2];
  int m_cnt[2];
  int a_err[2], a_hd[2], a_abs[2], a_max[2];
  int r_err[2], r_hd[2], r_abs[2], r_max[2];

  function automatic void mreset(input int k);
    t_done[k] = -1;
    m_cnt[k]  = 0;
    a_err[k]  = 0;
    a_hd[k]   = 0;
    a_abs[k]  = 0;
    a_max[k]  = 0;
  endfunction

  always @(negedge clk) begin : cmp
    bit eir, eov;
    int e, a, d;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mreset(k);
      end else begin
        eir = (t_done[k] < 0);
        eov = !eir && (cyc >= t_done[k] + 2);
        check($sformatf("in_ready[%0d]", k), 32'(o_ir[k]), 32'(eir));
        check($sformatf("out_valid[%0d]", k), 32'(o_ov[k]), 32'(eov));
        if (eov) begin
          check($sformatf("err_cnt[%0d]", k), o_err[k], 32'(r_err[k]));
          check($sformatf("hd_sum[%0d]", k), o_hd[k], 32'(r_hd[k]));
          check($sformatf("abs_sum[%0d]", k), o_abs[k], 32'(r_abs[k]));
          check($sformatf("max_abs[%0d]", k), o_max[k], 32'(r_max[k]));
        end
        if (clr_s[k]) begin
          mreset(k);
        end else if (eir && vin[k]) begin
          e = int'(ex[k]);
          a = int'(ap[k]);
          d = (e > a) ? e - a : a - e;
          a_err[k] += (e != a) ? 1 : 0;
          a_hd[k]  += $countones(ex[k] ^ ap[k]);
          a_abs[k] += d;
          if (d > a_max[k]) a_max[k] = d;
          m_cnt[k]++;
          if (m_cnt[k] == win[k]) begin
            r_err[k]  = a_err[k];
            r_hd[k]   = a_hd[k];
            r_abs[k]  = a_abs[k];
            r_max[k]  = a_max[k];
            a_err[k]  = 0;
            a_hd[k]   = 0;
            a_abs[k]  = 0;
            a_max[k]  = 0;
            m_cnt[k]  = 0;
            t_done[k] = cyc;
          end
        end else if (eov && ordy[k]) begin
          t_done[k] = -1;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until accepted; returns just after the accepting edge
  task automatic send(input int k, input int e, input int a);
    int guard;
    guard = 0;
    vin[k] = 1'b1;
    ex[k]  = 5'(e);
    ap[k]  = 5'(a);
    @(negedge clk);
    while (!o_ir[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_accept", 32'(o_ir[k]), 32'd1);
    sync();
    vin[k] = 1'b0;
  endtask

  // Count falling edges until out_valid shows; returns on that falling edge
  task automatic wait_ov(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ov[k] && n < 40);
    check("ov_rise", 32'(o_ov[k]), 32'd1);
  endtask

  task automatic lit(input string nm, input int k, input int e, input int h, input int a, input int m);
    check({nm, "_err"}, o_err[k], 32'(e));
    check({nm, "_hd"},  o_hd[k],  32'(h));
    check({nm, "_abs"}, o_abs[k], 32'(a));
    check({nm, "_max"}, o_max[k], 32'(m));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vin[k]   = 1'b0;
      ex[k]    = '0;
      ap[k]    = '0;
      ordy[k]  = 1'b1;
      clr_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir4), 32'd1);
    check("rst_out_valid", 32'(ov4), 32'd0);
    lit("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Basic window, consumer always ready
    send(0, 31, 31); send(0, 10, 12); send(0, 0, 31); send(0, 7, 6);
    wait_ov(0, n);
    check("t1_latency", 32'(n), 32'd2);
    lit("t1", 0, 3, 8, 34, 31);
    @(negedge clk);
    check("t1_ov_one_cycle", 32'(o_ov[0]), 32'd0);
    sync();

    // Same stream with back-pressure
    ordy[0] = 1'b0;
    send(0, 31, 31); send(0, 10, 12); send(0, 0, 31); send(0, 7, 6);
    wait_ov(0, n);
    repeat (10) @(negedge clk);
    lit("t2_held", 0, 3, 8, 34, 31);
    check("t2_in_ready_low", 32'(o_ir[0]), 32'd0);
    sync();
    ordy[0] = 1'b1;
    sync();

    // All-equal window, then the widest possible errors
    send(0, 5, 5); send(0, 0, 0); send(0, 31, 31); send(0, 17, 17);
    wait_ov(0, n);
    lit("t3_zero", 0, 0, 0, 0, 0);
    sync();
    for (int i = 0; i < 4; i++) send(0, 0, 31);
    wait_ov(0, n);
    lit("t3_max", 0, 4, 20, 124, 31);
    sync();

    // clr after the third accept discards the partial window
    send(0, 1, 2); send(0, 3, 3); send(0, 8, 0);
    clr_s[0] = 1'b1;
    sync();
    clr_s[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1, 0);
    wait_ov(0, n);
    check("t4_latency", 32'(n), 32'd2);
    lit("t4", 0, 4, 4, 4, 1);
    sync();

    // Asynchronous reset while a report is held
    ordy[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 31, 0);
    wait_ov(0, n);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ov_drop", 32'(ov4), 32'd0);
    check("t5_in_ready", 32'(ir4), 32'd1);
    lit("t5_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    check("t5_in_ready_after", 32'(o_ir[0]), 32'd1);
    sync();

    // WINDOW=1: one report per accepted pair
    send(1, 9, 2);
    wait_ov(1, n);
    check("t6_latency", 32'(n), 32'd2);
    lit("t6", 1, 1, 3, 7, 7);
    sync();
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) sync();
      send(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
    repeat (5) sync();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
